// File: rtl/wash_pkg.sv
// -----------------------------------------------------------------------------
// wash_pkg
// Shared definitions between the wash front panel and the wash controller:
// panel FSM state codes, load-size and temperature encodings, configuration
// field widths and the frozen configuration record.
// Ports: none (package).
// -----------------------------------------------------------------------------
package wash_pkg;

  localparam int SIZE_W = 2;
  localparam int TEMP_W = 2;

  // Positions of the raw panel inputs inside the debouncer bank.
  localparam int NUM_RAW   = 8;
  localparam int IDX_SIZE  = 0;  // sw1:sw0
  localparam int IDX_TEMP  = 2;  // sw3:sw2
  localparam int IDX_RINSE = 4;
  localparam int IDX_SPIN  = 5;
  localparam int IDX_LID   = 6;
  localparam int IDX_START = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } panel_state_e;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_SMALL  = 2'd0,
    SIZE_MEDIUM = 2'd1,
    SIZE_LARGE  = 2'd2,
    SIZE_XL     = 2'd3
  } size_e;

  typedef enum logic [TEMP_W-1:0] {
    TEMP_COLD = 2'd0,
    TEMP_WARM = 2'd1,
    TEMP_HOT  = 2'd2,
    TEMP_MAX  = 2'd3
  } temp_e;

  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic [TEMP_W-1:0] temp;
    logic              rinse2;
    logic              spin2;
  } wash_cfg_t;

endpackage

// File: rtl/panel_debounce.sv
// -----------------------------------------------------------------------------
// panel_debounce
// Two-flop synchronizer followed by a saturating stability counter. The output
// flips only after the synchronized input has disagreed with it on
// DEB_COUNT+1 consecutive clock edges; any agreeing sample restarts the count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous input
//   dout       : debounced, synchronous output (0 after reset)
// -----------------------------------------------------------------------------
module panel_debounce #(
  parameter int DEB_WIDTH = 16,
  parameter int DEB_COUNT = 50000 - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam logic [DEB_WIDTH-1:0] CNT_LAST = DEB_WIDTH'(DEB_COUNT);

  logic                 sync1_q, sync2_q;
  logic                 deb_q, deb_d;
  logic [DEB_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      deb_d = ~deb_q;
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      // Saturate rather than wrap in case CNT_LAST exceeds the counter range.
      cnt_d = cnt_q + DEB_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values, e.g. sync2_q takes the old sync1_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/wash_panel.sv
// -----------------------------------------------------------------------------
// wash_panel
// Front panel of the washing machine: debounces the switches, lid sensor and
// start button, freezes the wash configuration on a valid start press and
// handshakes a start request with the wash controller.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   sw0..sw6         : raw switches (size, temperature, rinse2, spin2, lid)
//   start_btn        : raw start button, active high
//   ctrl_busy        : controller is executing a cycle
//   ctrl_done        : one-cycle end-of-cycle pulse from the controller
//   start_req        : start request, held until ctrl_busy acknowledges it
//   cfg_size/temp    : configuration frozen at the accepted start press
//   cfg_rinse2/spin2 : frozen option bits
//   lid_open         : live debounced lid state
//   err_lid          : one-cycle pulse when the lid blocks or aborts a start
//   panel_state      : FSM state code (wash_pkg::panel_state_e)
// -----------------------------------------------------------------------------
module wash_panel
  import wash_pkg::*;
#(
  parameter int DEB_WIDTH = 16,
  parameter int DEB_COUNT = 50000 - 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw0,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  input  logic       sw4,
  input  logic       sw5,
  input  logic       sw6,
  input  logic       start_btn,
  input  logic       ctrl_busy,
  input  logic       ctrl_done,
  output logic       start_req,
  output logic [1:0] cfg_size,
  output logic [1:0] cfg_temp,
  output logic       cfg_rinse2,
  output logic       cfg_spin2,
  output logic       lid_open,
  output logic       err_lid,
  output logic [1:0] panel_state
);

  logic [NUM_RAW-1:0] raw_in;
  logic [NUM_RAW-1:0] deb;

  assign raw_in = {start_btn, sw6, sw5, sw4, sw3, sw2, sw1, sw0};

  for (genvar i = 0; i < NUM_RAW; i++) begin : g_deb
    panel_debounce #(
      .DEB_WIDTH (DEB_WIDTH),
      .DEB_COUNT (DEB_COUNT)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (raw_in[i]),
      .dout  (deb[i])
    );
  end

  logic deb_start, deb_lid, start_rise;

  assign deb_start = deb[IDX_START];
  assign deb_lid   = deb[IDX_LID];

  panel_state_e state_q, state_d;
  wash_cfg_t    cfg_q, cfg_d;
  logic         start_req_q, start_req_d;
  logic         err_lid_q, err_lid_d;
  logic         start_prev_q;

  // Only a fresh press starts a cycle; a button still held when the FSM gets
  // back to IDLE produces no edge here.
  assign start_rise = deb_start & ~start_prev_q;

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    start_req_d = start_req_q;
    err_lid_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          if (deb_lid) begin
            err_lid_d = 1'b1;
          end else begin
            cfg_d.size   = deb[IDX_SIZE +: SIZE_W];
            cfg_d.temp   = deb[IDX_TEMP +: TEMP_W];
            cfg_d.rinse2 = deb[IDX_RINSE];
            cfg_d.spin2  = deb[IDX_SPIN];
            start_req_d  = 1'b1;
            state_d      = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Acknowledge has priority: once the controller has taken the
        // request, the lid is the controller's concern.
        if (ctrl_busy) begin
          start_req_d = 1'b0;
          state_d     = ST_RUN;
        end else if (deb_lid) begin
          err_lid_d   = 1'b1;
          start_req_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ctrl_done) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!deb_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      start_req_q  <= 1'b0;
      err_lid_q    <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      start_req_q  <= start_req_d;
      err_lid_q    <= err_lid_d;
      start_prev_q <= deb_start;
    end
  end

  assign start_req   = start_req_q;
  assign cfg_size    = cfg_q.size;
  assign cfg_temp    = cfg_q.temp;
  assign cfg_rinse2  = cfg_q.rinse2;
  assign cfg_spin2   = cfg_q.spin2;
  assign lid_open    = deb_lid;
  assign err_lid     = err_lid_q;
  assign panel_state = state_q;

endmodule

// File: tb/tb_wash_panel.sv
// -----------------------------------------------------------------------------
// tb_wash_panel
// Directed self-checking bench for wash_panel with DEB_WIDTH=8, DEB_COUNT=9,
// so a debounced level change lands 12 edges after the raw change and a start
// request 13 edges after the press.
// -----------------------------------------------------------------------------
module tb_wash_panel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw0, sw1, sw2, sw3, sw4, sw5, sw6;
  logic       start_btn, ctrl_busy, ctrl_done;
  logic       start_req, cfg_rinse2, cfg_spin2, lid_open, err_lid;
  logic [1:0] cfg_size, cfg_temp, panel_state;

  int checks = 0;
  int errors = 0;
  bit saw_req;

  always #5 clk = ~clk;

  wash_panel #(
    .DEB_WIDTH (8),
    .DEB_COUNT (9)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw0         (sw0),
    .sw1         (sw1),
    .sw2         (sw2),
    .sw3         (sw3),
    .sw4         (sw4),
    .sw5         (sw5),
    .sw6         (sw6),
    .start_btn   (start_btn),
    .ctrl_busy   (ctrl_busy),
    .ctrl_done   (ctrl_done),
    .start_req   (start_req),
    .cfg_size    (cfg_size),
    .cfg_temp    (cfg_temp),
    .cfg_rinse2  (cfg_rinse2),
    .cfg_spin2   (cfg_spin2),
    .lid_open    (lid_open),
    .err_lid     (err_lid),
    .panel_state (panel_state)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; leave the bench 1 ns after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (start_req === 1'b1) saw_req = 1'b1;
    end
  endtask

  task automatic check_cfg(input string tag, input logic [1:0] size, input logic [1:0] temp,
                           input logic rinse2, input logic spin2);
    check(tag, {2'b00, cfg_size, cfg_temp, cfg_rinse2, cfg_spin2},
          {2'b00, size, temp, rinse2, spin2});
  endtask

  task automatic set_sw(input logic [1:0] size, input logic [1:0] temp,
                        input logic rinse2, input logic spin2);
    {sw1, sw0} = size;
    {sw3, sw2} = temp;
    sw4 = rinse2;
    sw5 = spin2;
  endtask

  initial begin
    rst_n = 1'b0;
    sw6 = 1'b0; start_btn = 1'b0; ctrl_busy = 1'b0; ctrl_done = 1'b0;
    set_sw(2'd2, 2'd1, 1'b1, 1'b0);
    saw_req = 1'b0;
    #3;
    check("reset_outputs", {start_req, err_lid, lid_open, panel_state, cfg_rinse2, cfg_spin2, 1'b0}, 8'h00);
    check_cfg("reset_cfg", 2'd0, 2'd0, 1'b0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(20);
    check("idle_after_reset", {5'd0, start_req, panel_state}, 8'h00);

    // Bouncing button: 5 high cycles never reach the 10-sample threshold.
    saw_req = 1'b0;
    for (int r = 0; r < 6; r++) begin
      start_btn = 1'b1; tick(5);
      start_btn = 1'b0; tick(1);
    end
    tick(15);
    check("bounce_no_req", {7'd0, saw_req}, 8'h00);
    check("bounce_state", {6'd0, panel_state}, 8'h00);

    // Clean press: start_req on the 13th edge after the press.
    start_btn = 1'b1;
    tick(12);
    check("req_not_early", {5'd0, start_req, panel_state}, 8'h00);
    tick(1);
    check("req_on_time", {7'd0, start_req}, 8'h01);
    check("req_state", {6'd0, panel_state}, 8'h01);
    check_cfg("cfg_capture1", 2'd2, 2'd1, 1'b1, 1'b0);

    // Acknowledge, then switch motion must not reach cfg_*.
    ctrl_busy = 1'b1;
    tick(1);
    check("ack_req_drop", {7'd0, start_req}, 8'h00);
    check("ack_state_run", {6'd0, panel_state}, 8'h02);
    set_sw(2'd1, 2'd2, 1'b0, 1'b1);
    tick(15);
    check_cfg("cfg_frozen_run", 2'd2, 2'd1, 1'b1, 1'b0);
    check("run_state", {6'd0, panel_state}, 8'h02);
    ctrl_done = 1'b1;
    tick(1);
    ctrl_done = 1'b0;
    check("done_state_hold", {6'd0, panel_state}, 8'h03);
    saw_req = 1'b0;
    tick(5);
    check("hold_while_pressed", {6'd0, panel_state}, 8'h03);
    start_btn = 1'b0;
    ctrl_busy = 1'b0;
    tick(12);
    check("hold_until_release", {6'd0, panel_state}, 8'h03);
    tick(1);
    check("hold_to_idle", {6'd0, panel_state}, 8'h00);
    tick(5);
    check("no_retrigger", {7'd0, saw_req}, 8'h00);
    check_cfg("cfg_frozen_hold", 2'd2, 2'd1, 1'b1, 1'b0);

    // Press with lid open: single err_lid pulse, no capture.
    sw6 = 1'b1;
    tick(13);
    check("lid_open_live", {7'd0, lid_open}, 8'h01);
    start_btn = 1'b1;
    tick(12);
    check("lid_err_not_early", {7'd0, err_lid}, 8'h00);
    tick(1);
    check("lid_err_pulse", {5'd0, err_lid, start_req, 1'b0}, 8'h04);
    check("lid_err_state", {6'd0, panel_state}, 8'h00);
    check_cfg("lid_err_cfg", 2'd2, 2'd1, 1'b1, 1'b0);
    tick(1);
    check("lid_err_one_cycle", {7'd0, err_lid}, 8'h00);
    start_btn = 1'b0;
    tick(15);
    sw6 = 1'b0;
    tick(15);
    check("lid_closed", {7'd0, lid_open}, 8'h00);

    // Busy and debounced lid-open seen on the same REQ edge: busy wins.
    start_btn = 1'b1;
    tick(13);
    check("req2_state", {6'd0, panel_state}, 8'h01);
    check_cfg("cfg_capture2", 2'd1, 2'd2, 1'b0, 1'b1);
    sw6 = 1'b1;
    tick(12);
    check("req2_lid_seen", {5'd0, lid_open, panel_state}, 8'h05);
    ctrl_busy = 1'b1;
    tick(1);
    check("busy_wins_state", {6'd0, panel_state}, 8'h02);
    check("busy_wins_no_err", {6'd0, err_lid, start_req}, 8'h00);

    // Mid-cycle asynchronous reset while running.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {start_req, err_lid, lid_open, panel_state, cfg_rinse2, cfg_spin2, 1'b0}, 8'h00);
    check_cfg("async_reset_cfg", 2'd0, 2'd0, 1'b0, 1'b0);
    ctrl_busy = 1'b0;
    start_btn = 1'b0;
    rst_n = 1'b1;
    tick(11);
    check("lid_after_reset_early", {7'd0, lid_open}, 8'h00);
    tick(1);
    check("lid_after_reset", {7'd0, lid_open}, 8'h01);

    // Lid opens in REQ without acknowledge: abort with err_lid.
    sw6 = 1'b0;
    tick(15);
    start_btn = 1'b1;
    tick(13);
    check("req3_state", {5'd0, start_req, panel_state}, 8'h05);
    sw6 = 1'b1;
    tick(12);
    check("req3_before_abort", {5'd0, err_lid, panel_state}, 8'h01);
    tick(1);
    check("abort_state", {6'd0, panel_state}, 8'h00);
    check("abort_err_req", {6'd0, err_lid, start_req}, 8'h02);
    tick(1);
    check("abort_err_one_cycle", {7'd0, err_lid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
